// File: rtl/layer_sequencer_if.sv
// Control and memory-port bundle for one fully-connected layer sequencer.
// Latency: none, wires only.
// Backpressure: none; the memory ports have a fixed one-cycle read latency.
interface layer_sequencer_if #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int WADDR_W = 16
);
    logic               start;
    logic [ADDR_W-1:0]  in_base;
    logic [ADDR_W-1:0]  in_count;
    logic [ADDR_W-1:0]  out_base;
    logic [ADDR_W-1:0]  out_count;
    logic [WADDR_W-1:0] w_base;
    logic               relu_en;
    logic               busy;
    logic               done;
    logic [ADDR_W-1:0]  rd_addr;
    logic [DATA_W-1:0]  rd_data;
    logic [WADDR_W-1:0] w_addr;
    logic [DATA_W-1:0]  w_data;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;

    modport master (
        input  start, in_base, in_count, out_base, out_count, w_base, relu_en,
        input  rd_data, w_data,
        output busy, done, rd_addr, w_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, in_base, in_count, out_base, out_count, w_base, relu_en,
        output rd_data, w_data,
        input  busy, done, rd_addr, w_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/layer_sequencer.sv
// Fully-connected layer sequencer: Q8.8 MAC over neuron/weight memories, saturating write-back.
// Latency: in_count+2 cycles per output neuron, done one cycle after the last write.
// Backpressure: none; start is sampled only in IDLE and ignored otherwise.
module layer_sequencer #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 16,
    parameter int WADDR_W   = 16,
    parameter int ACC_W     = 40,
    parameter int FRAC_BITS = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    layer_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0]  in_base_r, in_count_r, out_base_r, out_count_r;
    logic               relu_r;
    logic [ADDR_W-1:0]  k, j;
    logic [WADDR_W-1:0] w_row;
    logic               valid_d;
    logic signed [ACC_W-1:0] acc;

    logic last_k, last_j;
    logic signed [2*DATA_W-1:0] a_ext, b_ext, prod;
    logic signed [ACC_W-1:0]    shifted;
    logic [ACC_W-DATA_W:0]      hi;
    logic [DATA_W-1:0]          result;

    assign last_k = (k == in_count_r - ADDR_W'(1));
    assign last_j = (j == out_count_r - ADDR_W'(1));

    assign a_ext = {{DATA_W{bus.rd_data[DATA_W-1]}}, bus.rd_data};
    assign b_ext = {{DATA_W{bus.w_data[DATA_W-1]}}, bus.w_data};
    assign prod  = a_ext * b_ext;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        shifted     = acc >>> FRAC_BITS;
        hi          = shifted[ACC_W-1:DATA_W-1];
        result      = shifted[DATA_W-1:0];
        // Out of range when the bits above the result sign disagree with it.
        if (!((&hi) | (~|hi))) begin
            result = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
        if (relu_r && result[DATA_W-1]) begin
            result = '0;
        end
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.out_count == '0)     state_nxt = S_DONE;
                    else if (bus.in_count == '0) state_nxt = S_WRITE;
                    else                         state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                bus.busy = 1'b1;
                if (last_k) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                bus.busy  = 1'b1;
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                bus.busy    = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_addr = out_base_r + j;
                bus.wr_data = result;
                if (last_j)                 state_nxt = S_DONE;
                else if (in_count_r == '0)  state_nxt = S_WRITE;
                else                        state_nxt = S_LOAD;
            end
            S_DONE: begin
                bus.done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address registers are preloaded so they already show in_base+k during each LOAD cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_base_r   <= '0;
            in_count_r  <= '0;
            out_base_r  <= '0;
            out_count_r <= '0;
            relu_r      <= 1'b0;
            k           <= '0;
            j           <= '0;
            w_row       <= '0;
            valid_d     <= 1'b0;
            acc         <= '0;
            bus.rd_addr <= '0;
            bus.w_addr  <= '0;
        end else begin
            valid_d <= (state == S_LOAD);
            if (valid_d) begin
                acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
            end
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        in_base_r   <= bus.in_base;
                        in_count_r  <= bus.in_count;
                        out_base_r  <= bus.out_base;
                        out_count_r <= bus.out_count;
                        relu_r      <= bus.relu_en;
                        k           <= '0;
                        j           <= '0;
                        acc         <= '0;
                        w_row       <= bus.w_base;
                        if (bus.out_count != '0 && bus.in_count != '0) begin
                            bus.rd_addr <= bus.in_base;
                            bus.w_addr  <= bus.w_base;
                        end
                    end
                end
                S_LOAD: begin
                    if (!last_k) begin
                        k           <= k + ADDR_W'(1);
                        bus.rd_addr <= bus.rd_addr + ADDR_W'(1);
                        bus.w_addr  <= bus.w_addr + WADDR_W'(1);
                    end
                end
                S_WRITE: begin
                    acc <= '0;
                    k   <= '0;
                    if (!last_j) begin
                        j <= j + ADDR_W'(1);
                        if (in_count_r != '0) begin
                            w_row       <= w_row + WADDR_W'(in_count_r);
                            bus.rd_addr <= in_base_r;
                            bus.w_addr  <= w_row + WADDR_W'(in_count_r);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: memory model, write scoreboard, per-cycle timing checks.
// Latency: n/a. Backpressure: n/a.
// Flow: expected writes are queued before each start and popped on every wr_en.
module tb_layer_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b1;

    layer_sequencer_if bus ();

    layer_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] nmem [0:4095];
    logic [15:0] wmem [0:65535];

    always @(posedge clk) begin
        bus.rd_data <= nmem[bus.rd_addr];
        bus.w_data  <= wmem[bus.w_addr];
    end

    int errors = 0;
    int checks = 0;
    logic [27:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [11:0] ib, input int ic,
                                          input logic [15:0] wrow, input logic relu);
        longint sum;
        logic [15:0] r;
        sum = 0;
        for (int kk = 0; kk < ic; kk++) begin
            logic [11:0] a;
            logic [15:0] wa;
            a  = ib + kk[11:0];
            wa = wrow + kk[15:0];
            sum += longint'($signed(nmem[a])) * longint'($signed(wmem[wa]));
        end
        sum = sum >>> 8;
        if (sum > 32767)       r = 16'h7FFF;
        else if (sum < -32768) r = 16'h8000;
        else                   r = sum[15:0];
        if (relu && r[15]) r = 16'h0000;
        return r;
    endfunction

    task automatic run_layer(input string tag, input logic [11:0] ib, input logic [11:0] ic,
                             input logic [11:0] ob, input logic [11:0] oc,
                             input logic [15:0] wb, input logic relu, input int poke);
        int ici, oci, exp_done, p, jj;
        logic exp_wr;
        logic [27:0] e;
        logic [11:0] ea;
        logic [15:0] ew;
        ici = int'(ic);
        oci = int'(oc);
        if (oci == 0)      exp_done = 1;
        else if (ici == 0) exp_done = oci + 1;
        else               exp_done = oci * (ici + 2) + 1;
        bus.start     = 1'b1;
        bus.in_base   = ib;
        bus.in_count  = ic;
        bus.out_base  = ob;
        bus.out_count = oc;
        bus.w_base    = wb;
        bus.relu_en   = relu;
        for (int cyc = 1; cyc <= exp_done + 2; cyc++) begin
            @(negedge clk);
            exp_wr = (oci != 0) && (cyc < exp_done) && ((ici == 0) || (cyc % (ici + 2) == 0));
            chk($sformatf("%s_busy_c%0d", tag, cyc), {31'd0, bus.busy}, {31'd0, cyc < exp_done});
            chk($sformatf("%s_done_c%0d", tag, cyc), {31'd0, bus.done}, {31'd0, cyc == exp_done});
            chk($sformatf("%s_wr_en_c%0d", tag, cyc), {31'd0, bus.wr_en}, {31'd0, exp_wr});
            if (bus.wr_en === 1'b1) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL %s_extra_write_c%0d: observed=write to %h expected=none", tag, cyc, bus.wr_addr);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk($sformatf("%s_wr_addr_c%0d", tag, cyc), {20'd0, bus.wr_addr}, {20'd0, e[27:16]});
                    chk($sformatf("%s_wr_data_c%0d", tag, cyc), {16'd0, bus.wr_data}, {16'd0, e[15:0]});
                end
            end
            if (ici != 0 && cyc < exp_done) begin
                p = (cyc - 1) % (ici + 2);
                if (p < ici) begin
                    jj = (cyc - 1) / (ici + 2);
                    ea = ib + p[11:0];
                    ew = wb + 16'(jj * ici) + p[15:0];
                    chk($sformatf("%s_rd_addr_c%0d", tag, cyc), {20'd0, bus.rd_addr}, {20'd0, ea});
                    chk($sformatf("%s_w_addr_c%0d", tag, cyc), {16'd0, bus.w_addr}, {16'd0, ew});
                end
            end
            if (cyc == 1) begin
                bus.start     = 1'b0;
                bus.in_base   = 12'h555;
                bus.in_count  = 12'h007;
                bus.out_base  = 12'hABC;
                bus.out_count = 12'h009;
                bus.w_base    = 16'h1234;
                bus.relu_en   = ~relu;
            end
            if (cyc == poke)     bus.start = 1'b1;
            if (cyc == poke + 1) bus.start = 1'b0;
        end
        chk({tag, "_queue_left"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++)  nmem[i] = 16'h0000;
        for (int i = 0; i < 65536; i++) wmem[i] = 16'h0000;
        bus.start     = 1'b0;
        bus.in_base   = '0;
        bus.in_count  = '0;
        bus.out_base  = '0;
        bus.out_count = '0;
        bus.w_base    = '0;
        bus.relu_en   = 1'b0;

        #1 reset_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        chk("rst_rd_addr", {20'd0, bus.rd_addr}, 32'd0);
        chk("rst_w_addr", {16'd0, bus.w_addr}, 32'd0);
        chk("rst_wr_addr", {20'd0, bus.wr_addr}, 32'd0);
        chk("rst_wr_data", {16'd0, bus.wr_data}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        nmem[0] = 16'h0001;
        nmem[1] = 16'h0200;
        nmem[2] = 16'hFF00;
        wmem[16'h0010] = 16'h0100;
        wmem[16'h0011] = 16'h0180;
        wmem[16'h0012] = 16'h0200;
        exp_q.push_back({12'h100, 16'h0101});
        run_layer("mac", 12'h000, 12'd3, 12'h100, 12'd1, 16'h0010, 1'b0, -10);

        wmem[16'h0011] = 16'h0000;
        exp_q.push_back({12'h100, 16'h0000});
        run_layer("relu_on", 12'h000, 12'd3, 12'h100, 12'd1, 16'h0010, 1'b1, -10);
        exp_q.push_back({12'h101, 16'hFE01});
        run_layer("relu_off", 12'h000, 12'd3, 12'h101, 12'd1, 16'h0010, 1'b0, -10);

        nmem[12'h020] = 16'h7FFF;
        nmem[12'h021] = 16'h7FFF;
        wmem[16'h0040] = 16'h7FFF;
        wmem[16'h0041] = 16'h7FFF;
        wmem[16'h0050] = 16'h8000;
        wmem[16'h0051] = 16'h8000;
        exp_q.push_back({12'h200, 16'h7FFF});
        run_layer("sat_pos", 12'h020, 12'd2, 12'h200, 12'd1, 16'h0040, 1'b0, -10);
        exp_q.push_back({12'h201, 16'h8000});
        run_layer("sat_neg", 12'h020, 12'd2, 12'h201, 12'd1, 16'h0050, 1'b0, -10);

        nmem[12'h030] = 16'h0180;
        nmem[12'h031] = 16'hFF40;
        wmem[16'h0200] = 16'h0100;
        wmem[16'h0201] = 16'h0200;
        wmem[16'h0202] = 16'hFF00;
        wmem[16'h0203] = 16'h0080;
        wmem[16'h0204] = 16'h0300;
        wmem[16'h0205] = 16'h0400;
        for (int o = 0; o < 3; o++)
            exp_q.push_back({12'h300 + o[11:0], model(12'h030, 2, 16'h0200 + 16'(o * 2), 1'b0)});
        run_layer("multi", 12'h030, 12'd2, 12'h300, 12'd3, 16'h0200, 1'b0, -10);

        nmem[12'hFFF] = 16'h0300;
        wmem[16'hFFFF] = 16'h0100;
        wmem[16'h0000] = 16'h0100;
        exp_q.push_back({12'h400, 16'h0301});
        run_layer("wrap", 12'hFFF, 12'd2, 12'h400, 12'd1, 16'hFFFF, 1'b0, -10);

        run_layer("oc0", 12'h000, 12'd3, 12'h500, 12'd0, 16'h0010, 1'b0, -10);

        exp_q.push_back({12'h600, 16'h0000});
        exp_q.push_back({12'h601, 16'h0000});
        run_layer("ic0", 12'h000, 12'd0, 12'h600, 12'd2, 16'h0010, 1'b0, -10);

        // Abort a layer in LOAD and confirm nothing is ever written.
        bus.start     = 1'b1;
        bus.in_base   = 12'h000;
        bus.in_count  = 12'd3;
        bus.out_base  = 12'h700;
        bus.out_count = 12'd1;
        bus.w_base    = 16'h0010;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        chk("arst_rd_addr", {20'd0, bus.rd_addr}, 32'd0);
        chk("arst_w_addr", {16'd0, bus.w_addr}, 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("arst_hold_wr_en_%0d", c), {31'd0, bus.wr_en}, 32'd0);
            chk($sformatf("arst_hold_done_%0d", c), {31'd0, bus.done}, 32'd0);
        end
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_wr_en_%0d", c), {31'd0, bus.wr_en}, 32'd0);
            chk($sformatf("post_rst_busy_%0d", c), {31'd0, bus.busy}, 32'd0);
        end

        wmem[16'h0203] = 16'hFE00;
        for (int o = 0; o < 3; o++)
            exp_q.push_back({12'h800 + o[11:0], model(12'h030, 2, 16'h0200 + 16'(o * 2), 1'b1)});
        run_layer("poke", 12'h030, 12'd2, 12'h800, 12'd3, 16'h0200, 1'b1, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Initiator for the neuron memory. It drives the memory read port (address in, 16-bit value out one cycle later) and the memory write port (write enable, address, data).
- For one fully-connected layer it does the following for each output neuron:
  - reads the input neurons;
  - fetches the matching weights;
  - multiply-accumulates them in Q8.8 fixed point;
  - optionally applies ReLU;
  - saturates the result and writes it back to the output neuron region.
- Neuron address 0 holds the constant 1 (bias neuron). A layer that includes in_base=0 therefore gets its bias from the first weight.

Parameters:
- ADDR_W, 12, neuron address width.
- DATA_W, 16, neuron/weight width, signed Q8.8.
- WADDR_W, 16, weight address width.
- ACC_W, 40, signed accumulator width.
- FRAC_BITS, 8, fractional bits of DATA_W.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous reset, active low.
- start  in  1  begin layer; sampled only in IDLE.
- in_base  in  ADDR_W  first input neuron address.
- in_count  in  ADDR_W  number of inputs per output, bias included.
- out_base  in  ADDR_W  first output neuron address.
- out_count  in  ADDR_W  number of output neurons.
- w_base  in  WADDR_W  first weight address.
- relu_en  in  1  clamp negative results to 0.
- busy  out  1  high in LOAD, DRAIN and WRITE.
- done  out  1  one-cycle pulse when the layer is complete.
- rd_addr  out  ADDR_W  neuron memory read address.
- rd_data  in  DATA_W  neuron value, valid one cycle after rd_addr.
- w_addr  out  WADDR_W  weight memory read address.
- w_data  in  DATA_W  weight value, valid one cycle after w_addr.
- wr_en  out  1  neuron memory write enable.
- wr_addr  out  ADDR_W  neuron memory write address.
- wr_data  out  DATA_W  value to write.

Behaviour:
- Reset:
  - reset_n low forces IDLE immediately, independent of clk.
  - Counters and accumulator are cleared.
  - busy, done, wr_en, rd_addr, w_addr, wr_addr and wr_data are all 0.
- Register latching:
  - in_base, in_count, out_base, out_count, w_base and relu_en are latched on the clock edge where start=1 in IDLE.
  - Changes to them while busy have no effect.
  - start while busy or in DONE is ignored.
- Counters: k = input index, j = output index.
- State IDLE, on start:
  - out_count==0: go to DONE.
  - in_count==0: go to WRITE with acc=0.
  - otherwise: go to LOAD with k=0, j=0.
- State LOAD, every cycle:
  - Drive rd_addr = in_base+k and w_addr = w_base + j*in_count + k.
  - Register valid_d=1.
  - k++.
  - After issuing k = in_count-1, go to DRAIN.
- Accumulate:
  - On any cycle with valid_d=1, acc += sign-extended (rd_data * w_data).
  - The product is a full 32-bit signed value.
- State DRAIN: one cycle, in which the last product accumulates; then go to WRITE.
- State WRITE:
  - Result = acc >>> FRAC_BITS (arithmetic shift).
  - Saturate to [0x8000, 0x7FFF].
  - If relu_en and the result is negative, result = 0.
  - Drive wr_en=1, wr_addr = out_base+j, wr_data = result for exactly this cycle.
  - Clear acc and k.
  - If j == out_count-1, go to DONE.
  - Otherwise j++, then go to LOAD, or stay in WRITE for the next output if in_count==0.
- State DONE: done=1 for one cycle, busy=0; then go to IDLE.
- Latency: in_count+2 cycles per output neuron; done asserts one cycle after the last wr_en.
- Address arithmetic:
  - All address sums wrap modulo 2^ADDR_W or 2^WADDR_W.
  - The weight index uses j*in_count truncated to WADDR_W.
- Output hold and overlap:
  - rd_addr and w_addr hold their last value outside LOAD.
  - wr_en is 0 outside WRITE.
  - The input and output regions must not overlap. The caller guarantees this, and the block performs no hazard check.
- Reset mid-operation: aborts with no further writes. A write already issued on an earlier edge stands.

Test Plan:
- Basic MAC:
  - Memory setup: mem[0]=0x0001 (bias neuron); inputs x1=0x0200, x2=0xFF00; weights 0x0100 (bias), 0x0180, 0x0200.
  - Scaling note: mem[0] holds the integer 1, not Q8.8 1.0 (0x0100). So bias weight 0x0100 yields a bias term of 0x0001 after the shift.
  - Stimulus: in_base=0, in_count=3, out_count=1, relu_en=0, out_base=0x100; start at cycle 0.
  - Response: LOAD in cycles 1-3, wr_en in cycle 5 with wr_addr=0x100, wr_data=0x0101, done in cycle 6.
  - Derivation: (0x100 + 0x30000 − 0x20000) >>> 8 = 0x0101, i.e. 0x0001 + 0x0300 − 0x0200.
- ReLU: same setup with w1=0x0000 and relu_en=1 (result 0x0001 − 0x0200 < 0) -> wr_data=0x0000; with relu_en=0 -> wr_data=0xFE01.
- Saturation:
  - in_count=2, inputs 0x7FFF,0x7FFF, weights 0x7FFF,0x7FFF -> 0x7FFF.
  - Weights 0x8000,0x8000 with inputs 0x7FFF -> 0x8000.
- Multi-output:
  - out_count=3, in_count=2.
  - Required: w_addr sequence w_base+0,1,2,3,4,5; wr_addr out_base, out_base+1, out_base+2; consecutive wr_en 4 cycles apart; single done pulse.
- Degenerate counts:
  - out_count=0 -> done on cycle 1, no wr_en ever.
  - in_count=0, out_count=2 -> two writes of 0x0000, then done.
- Reset and ignored start:
  - reset_n low during LOAD -> busy/wr_en/addresses are 0 asynchronously and no write occurs.
  - After release, a start pulse issued while busy mid-layer is ignored: only out_count writes occur and latched parameters are unchanged.
